sync_fifo_param: RTL

Parametrised single-clock FIFO for the sync FIFO datapath, generalised in data width and depth. It adds the following over the fixed 8x16 design:
- an occupancy count output;
- programmable almost-full and almost-empty thresholds;
- a read-valid strobe;
- sticky overflow and underflow error flags.

It sits between a producer and a consumer that share clk. External logic drives wr_en and rd_en directly; the FIFO generates no internal traffic.

---
 rtl/sync_fifo_param_if.sv | 40 ++++
 rtl/sync_fifo_param.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
//   Handshake / status bundle for sync_fifo_param. The clock and reset stay
//   plain ports on the FIFO; everything else travels through this interface.
//
//   master : producer/consumer side (drives wr_en, data_in, rd_en, clr_err)
//   slave  : FIFO side (drives data, read strobe, occupancy and flags)
//
//   DATA_W / ADDR_W must match the parameters of the FIFO it is bound to.
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en, clr_err,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, clr_err,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock FIFO, DEPTH = 2**ADDR_W words of DATA_W bits, with
//   registered occupancy count, programmable almost-full / almost-empty
//   thresholds, a one-cycle read-valid strobe and sticky overflow/underflow.
//
//   Ports:
//     clk   - rising-edge clock for all state
//     rst   - asynchronous, active-low reset (clears pointers, count, flags,
//             data_out, rd_valid; memory contents are left as they are)
//     fifo  - sync_fifo_param_if.slave:
//               wr_en/data_in   write request and data
//               rd_en           read request; data_out valid one clock later
//               rd_valid        high for the cycle data_out carries new data
//               count           occupancy 0..DEPTH
//               full/empty/almost_full/almost_empty  decoded from count
//               overflow/underflow  sticky error flags, cleared by clr_err
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_param_if.slave fifo
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    // Storage: synchronous write port, read is captured into data_out_q.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full, empty, almost_full, almost_empty;
    logic wr_acc, rd_acc;

    // Status comes only from the registered count, so no input reaches
    // these outputs combinationally.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
    end

    always_comb begin
        wr_acc      = fifo.wr_en && !full;
        rd_acc      = fifo.rd_en && !empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end

        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + ONE_C;
            data_out_d = mem[rd_ptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end

        // Simultaneous accepted read and write leave occupancy unchanged.
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Clear first, then a new error in the same cycle re-sets the flag.
        overflow_d  = (overflow_q  && !fifo.clr_err) || (fifo.wr_en && full);
        underflow_d = (underflow_q && !fifo.clr_err) || (fifo.rd_en && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= fifo.data_in;
        end
    end

    assign fifo.data_out     = data_out_q;
    assign fifo.rd_valid     = rd_valid_q;
    assign fifo.count        = count_q;
    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = almost_full;
    assign fifo.almost_empty = almost_empty;
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule
